// File: rtl/dti_pack.sv
// Shared DTI widths and types for the master-side request mux.
package dti_pack;

    localparam int unsigned AXIS_DATA_WIDTH       = 32;
    localparam int unsigned AXIS_KEEP_WIDTH       = AXIS_DATA_WIDTH / 8;
    localparam int unsigned CUSTOM_DATA_WIDTH     = 32;
    localparam int unsigned CUSTOM_KEEP_WIDTH     = CUSTOM_DATA_WIDTH / 8;
    localparam int unsigned TBU_NUM_WIDTH         = 5;
    localparam int unsigned DTI_MUX_ERR_CNT_WIDTH = 8;

    typedef enum logic {
        MUX_ARB,
        MUX_LOCK
    } dti_mux_state_e;

endpackage

// File: rtl/dti_rr_arb.sv
// Round-robin picker: first asserted request at or after ptr_i, wrapping.
module dti_rr_arb #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    logic [IdxW-1:0] cand;

    // Walk from the farthest offset down so the closest hit to ptr_i wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int off = int'(N) - 1; off >= 0; off--) begin
            cand = IdxW'((32'(ptr_i) + 32'(off)) % N);
            if (req_i[cand]) begin
                gnt_o       = '0;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dti_pr_req_mux.sv
// Packet-level N:1 request arbiter with ttid stamping and 1:N response router by ttid.
module dti_pr_req_mux
    import dti_pack::*;
#(
    parameter int unsigned PORT_NUM = 4,
    parameter int unsigned TID_BASE = 0
) (
    input  logic                                         clk,
    input  logic                                         rst,

    input  logic [PORT_NUM-1:0]                          s_req_tvalid,
    input  logic [PORT_NUM-1:0][AXIS_DATA_WIDTH-1:0]     s_req_tdata,
    input  logic [PORT_NUM-1:0][AXIS_KEEP_WIDTH-1:0]     s_req_tkeep,
    input  logic [PORT_NUM-1:0]                          s_req_tlast,
    output logic [PORT_NUM-1:0]                          s_req_tready,

    output logic                                         req_tvalid,
    output logic [AXIS_DATA_WIDTH-1:0]                   req_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]                   req_tkeep,
    output logic                                         req_tlast,
    output logic [TBU_NUM_WIDTH-1:0]                     req_ttid,
    input  logic                                         req_tready,

    input  logic                                         rsp_tvalid,
    input  logic [CUSTOM_DATA_WIDTH-1:0]                 rsp_tdata,
    input  logic [CUSTOM_KEEP_WIDTH-1:0]                 rsp_tkeep,
    input  logic                                         rsp_tlast,
    input  logic [TBU_NUM_WIDTH-1:0]                     rsp_ttid,
    output logic                                         rsp_tready,

    output logic [PORT_NUM-1:0]                          m_rsp_tvalid,
    output logic [CUSTOM_DATA_WIDTH-1:0]                 m_rsp_tdata,
    output logic [CUSTOM_KEEP_WIDTH-1:0]                 m_rsp_tkeep,
    output logic                                         m_rsp_tlast,
    input  logic [PORT_NUM-1:0]                          m_rsp_tready,

    output logic                                         idle,
    output logic [DTI_MUX_ERR_CNT_WIDTH-1:0]             rsp_err_cnt
);

    localparam int unsigned IdxW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    dti_mux_state_e                  state_q;
    logic [IdxW-1:0]                 gnt_q;
    logic [IdxW-1:0]                 rr_ptr_q;
    logic                            req_valid_q;
    logic [AXIS_DATA_WIDTH-1:0]      req_data_q;
    logic [AXIS_KEEP_WIDTH-1:0]      req_keep_q;
    logic                            req_last_q;
    logic [TBU_NUM_WIDTH-1:0]        req_tid_q;
    logic                            rsp_open_q;
    logic [DTI_MUX_ERR_CNT_WIDTH-1:0] err_cnt_q;

    logic [PORT_NUM-1:0] arb_gnt;
    logic [IdxW-1:0]     arb_idx;
    logic                arb_valid;
    logic [IdxW-1:0]     sel_idx;
    logic                sel_valid;
    logic                sel_last;
    logic                load;
    logic                fire;
    logic [IdxW-1:0]     ptr_next;

    dti_rr_arb #(
        .N    (PORT_NUM),
        .IdxW (IdxW)
    ) u_arb (
        .req_i   (s_req_tvalid),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign load = !req_valid_q || req_tready;

    always_comb begin
        s_req_tready = '0;
        if (state_q == MUX_LOCK) begin
            sel_idx               = gnt_q;
            sel_valid             = s_req_tvalid[gnt_q];
            s_req_tready[gnt_q]   = load;
        end else begin
            sel_idx      = arb_idx;
            sel_valid    = arb_valid;
            s_req_tready = load ? arb_gnt : '0;
        end
    end

    assign fire     = sel_valid && load;
    assign sel_last = s_req_tlast[sel_idx];
    assign ptr_next = (32'(sel_idx) == PORT_NUM - 1) ? '0 : sel_idx + 1'b1;

    // Packet lock FSM together with the single output register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MUX_ARB;
            gnt_q       <= '0;
            rr_ptr_q    <= '0;
            req_valid_q <= 1'b0;
            req_data_q  <= '0;
            req_keep_q  <= '0;
            req_last_q  <= 1'b0;
            req_tid_q   <= '0;
        end else begin
            if (load) begin
                req_valid_q <= sel_valid;
                if (fire) begin
                    req_data_q <= s_req_tdata[sel_idx];
                    req_keep_q <= s_req_tkeep[sel_idx];
                    req_last_q <= sel_last;
                    req_tid_q  <= TBU_NUM_WIDTH'(TID_BASE + 32'(sel_idx));
                end
            end
            case (state_q)
                MUX_ARB: begin
                    if (fire) begin
                        rr_ptr_q <= ptr_next;
                        if (!sel_last) begin
                            gnt_q   <= sel_idx;
                            state_q <= MUX_LOCK;
                        end
                    end
                end
                MUX_LOCK: begin
                    if (fire && sel_last) begin
                        state_q <= MUX_ARB;
                    end
                end
            endcase
        end
    end

    assign req_tvalid = req_valid_q;
    assign req_tdata  = req_data_q;
    assign req_tkeep  = req_keep_q;
    assign req_tlast  = req_last_q;
    assign req_ttid   = req_tid_q;

    // Tags below TID_BASE wrap to large offsets and fall out of range too.
    logic [31:0]     rsp_off;
    logic            rsp_hit;
    logic [IdxW-1:0] rsp_idx;

    assign rsp_off = 32'(rsp_ttid) - TID_BASE;
    assign rsp_hit = rsp_off < PORT_NUM;
    assign rsp_idx = rsp_off[IdxW-1:0];

    always_comb begin
        m_rsp_tvalid = '0;
        rsp_tready   = 1'b1;
        if (rsp_hit) begin
            m_rsp_tvalid[rsp_idx] = rsp_tvalid;
            rsp_tready            = m_rsp_tready[rsp_idx];
        end
    end

    assign m_rsp_tdata = rsp_tdata;
    assign m_rsp_tkeep = rsp_tkeep;
    assign m_rsp_tlast = rsp_tlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_open_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            if (rsp_tvalid && rsp_tready) begin
                rsp_open_q <= !rsp_tlast;
            end
            if (rsp_tvalid && !rsp_hit && rsp_tlast && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign rsp_err_cnt = err_cnt_q;
    assign idle        = (state_q == MUX_ARB) && !req_valid_q && !rsp_open_q;

endmodule

// File: tb/tb_dti_pr_req_mux.sv
// Self-checking bench: per-port packet scoreboard plus directed and random scenarios.
module tb_dti_pr_req_mux;
    import dti_pack::*;

    localparam int unsigned NP = 4;
    localparam int          TB = 8;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic                         clk;
    logic                         rst;
    logic [NP-1:0]                s_req_tvalid;
    logic [NP-1:0][31:0]          s_req_tdata;
    logic [NP-1:0][3:0]           s_req_tkeep;
    logic [NP-1:0]                s_req_tlast;
    logic [NP-1:0]                s_req_tready;
    logic                         req_tvalid;
    logic [31:0]                  req_tdata;
    logic [3:0]                   req_tkeep;
    logic                         req_tlast;
    logic [4:0]                   req_ttid;
    logic                         req_tready;
    logic                         rsp_tvalid;
    logic [31:0]                  rsp_tdata;
    logic [3:0]                   rsp_tkeep;
    logic                         rsp_tlast;
    logic [4:0]                   rsp_ttid;
    logic                         rsp_tready;
    logic [NP-1:0]                m_rsp_tvalid;
    logic [31:0]                  m_rsp_tdata;
    logic [3:0]                   m_rsp_tkeep;
    logic                         m_rsp_tlast;
    logic [NP-1:0]                m_rsp_tready;
    logic                         idle;
    logic [7:0]                   rsp_err_cnt;

    dti_pr_req_mux #(
        .PORT_NUM (NP),
        .TID_BASE (TB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_req_tvalid (s_req_tvalid),
        .s_req_tdata  (s_req_tdata),
        .s_req_tkeep  (s_req_tkeep),
        .s_req_tlast  (s_req_tlast),
        .s_req_tready (s_req_tready),
        .req_tvalid   (req_tvalid),
        .req_tdata    (req_tdata),
        .req_tkeep    (req_tkeep),
        .req_tlast    (req_tlast),
        .req_ttid     (req_ttid),
        .req_tready   (req_tready),
        .rsp_tvalid   (rsp_tvalid),
        .rsp_tdata    (rsp_tdata),
        .rsp_tkeep    (rsp_tkeep),
        .rsp_tlast    (rsp_tlast),
        .rsp_ttid     (rsp_ttid),
        .rsp_tready   (rsp_tready),
        .m_rsp_tvalid (m_rsp_tvalid),
        .m_rsp_tdata  (m_rsp_tdata),
        .m_rsp_tkeep  (m_rsp_tkeep),
        .m_rsp_tlast  (m_rsp_tlast),
        .m_rsp_tready (m_rsp_tready),
        .idle         (idle),
        .rsp_err_cnt  (rsp_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    beat_t drv_q[NP][$];
    beat_t exp_q[NP][$];
    int    acc_cnt[NP];
    logic [NP-1:0] acc;
    int    rdy_mode = 0;
    bit    flush = 0;
    bit    open = 0;
    int    open_port = 0;
    bit    stall_prev = 0;
    logic [42:0] held;
    int    out_ports[$];
    int    out_cyc[$];
    int    in_cyc[$];
    int    exp_err = 0;

    // Monitor: input handshakes, output stall stability and per-port packet scoreboard.
    initial begin
        int    port;
        beat_t got;
        beat_t want;
        forever begin
            @(negedge clk);
            cyc++;
            for (int p = 0; p < int'(NP); p++) begin
                acc[p] = s_req_tvalid[p] && s_req_tready[p];
                if (acc[p]) begin
                    acc_cnt[p]++;
                    in_cyc.push_back(cyc);
                end
            end
            if (rst) begin
                stall_prev = 0;
            end else begin
                if (stall_prev) begin
                    checks++;
                    if ({req_tdata, req_tkeep, req_tlast, req_ttid, req_tvalid} !== held) begin
                        errors++;
                        $display("FAIL stall_hold: got %0h expected %0h",
                                 {req_tdata, req_tkeep, req_tlast, req_ttid, req_tvalid}, held);
                    end
                end
                stall_prev = req_tvalid && !req_tready;
                held = {req_tdata, req_tkeep, req_tlast, req_ttid, req_tvalid};
                if (req_tvalid && req_tready) begin
                    port = int'(req_ttid) - TB;
                    checks++;
                    if (port < 0 || port >= int'(NP) || (open && port != open_port) ||
                        exp_q[port].size() == 0) begin
                        errors++;
                        $display("FAIL out_port: got ttid %0d expected open=%0b port %0d",
                                 req_ttid, open, open_port);
                    end else begin
                        got  = '{data: req_tdata, keep: req_tkeep, last: req_tlast};
                        want = exp_q[port].pop_front();
                        checks++;
                        if (got !== want) begin
                            errors++;
                            $display("FAIL out_beat port %0d: got %0h expected %0h",
                                     port, got, want);
                        end
                        if (!open) out_ports.push_back(port);
                        open      = !req_tlast;
                        open_port = port;
                        out_cyc.push_back(cyc);
                    end
                end
            end
        end
    end

    // Driver: masters present queued beats, downstream ready per rdy_mode.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (flush) begin
                for (int p = 0; p < int'(NP); p++) drv_q[p].delete();
                flush = 0;
            end else begin
                for (int p = 0; p < int'(NP); p++) begin
                    if (acc[p] && drv_q[p].size() > 0) void'(drv_q[p].pop_front());
                end
            end
            for (int p = 0; p < int'(NP); p++) begin
                s_req_tvalid[p] = drv_q[p].size() > 0;
                if (drv_q[p].size() > 0) begin
                    s_req_tdata[p] = drv_q[p][0].data;
                    s_req_tkeep[p] = drv_q[p][0].keep;
                    s_req_tlast[p] = drv_q[p][0].last;
                end
            end
            req_tready = (rdy_mode == 0) ? 1'b1 :
                         (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic send(input int p, input int len, input bit fixed);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = fixed ? 32'hA + 32'(i) : $urandom;
            b.keep = fixed ? 4'hF : 4'($urandom);
            b.last = (i == len - 1);
            drv_q[p].push_back(b);
            exp_q[p].push_back(b);
        end
    endtask

    function automatic bit pending();
        for (int p = 0; p < int'(NP); p++) begin
            if (drv_q[p].size() != 0 || exp_q[p].size() != 0) return 1'b1;
        end
        return req_tvalid;
    endfunction

    task automatic clear_logs();
        out_ports.delete();
        out_cyc.delete();
        in_cyc.delete();
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (pending() && n < 3000) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL drain_%s: got pending after %0d cycles expected empty", name, n);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        for (int p = 0; p < int'(NP); p++) exp_q[p].delete();
        open    = 0;
        exp_err = 0;
        rst     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (req_tvalid !== 1'b0) begin
            errors++; $display("FAIL rst_tvalid: got %0b expected 0", req_tvalid);
        end
        checks++;
        if ({req_tdata, req_tkeep, req_tlast, req_ttid} !== 42'd0) begin
            errors++;
            $display("FAIL rst_payload: got %0h expected 0",
                     {req_tdata, req_tkeep, req_tlast, req_ttid});
        end
        checks++;
        if (rsp_err_cnt !== 8'd0) begin
            errors++; $display("FAIL rst_err_cnt: got %0d expected 0", rsp_err_cnt);
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++; $display("FAIL rst_idle: got %0b expected 1", idle);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_packet();
        clear_logs();
        send(2, 3, 1'b1);
        wait_drain("single");
        checks++;
        if (out_ports.size() != 1 || out_ports[0] != 2) begin
            errors++;
            $display("FAIL single_port: got %0d packets expected 1 from port 2", out_ports.size());
        end
        checks++;
        if (out_cyc.size() != 3 || in_cyc.size() != 3 || out_cyc[0] != in_cyc[0] + 1 ||
            out_cyc[2] != out_cyc[0] + 2) begin
            errors++;
            $display("FAIL single_latency: got %0d out beats expected 3 at 1-cycle latency",
                     out_cyc.size());
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++; $display("FAIL single_idle: got %0b expected 1", idle);
        end
    endtask

    task automatic test_contention();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        clear_logs();
        for (int p = 0; p < int'(NP); p++) send(p, 2, 1'b0);
        send(0, 2, 1'b0);
        wait_drain("contention");
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= out_ports.size() || out_ports[i] != exp_order[i]) begin
                errors++;
                $display("FAIL grant_order[%0d]: got %0d expected %0d", i,
                         (i < out_ports.size()) ? out_ports[i] : -1, exp_order[i]);
            end
        end
        checks++;
        if (out_cyc.size() != 10 || out_cyc[9] - out_cyc[0] != 9) begin
            errors++;
            $display("FAIL contention_bubble: got %0d beats expected 10 back to back",
                     out_cyc.size());
        end
    endtask

    task automatic test_backpressure();
        int base = acc_cnt[1];
        int n = 0;
        send(1, 6, 1'b0);
        while (acc_cnt[1] < base + 2 && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        rdy_mode = 2;
        @(posedge clk);
        #2;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (s_req_tready[1] !== 1'b0 || req_tvalid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold: got tready=%0b tvalid=%0b expected 0/1",
                         s_req_tready[1], req_tvalid);
            end
            @(posedge clk);
            #2;
        end
        rdy_mode = 0;
        wait_drain("backpressure");
        checks++;
        if (acc_cnt[1] - base != 6) begin
            errors++;
            $display("FAIL bp_beats: got %0d expected 6", acc_cnt[1] - base);
        end
    endtask

    task automatic test_random_traffic();
        rdy_mode = 1;
        for (int r = 0; r < 25; r++) begin
            for (int p = 0; p < int'(NP); p++) begin
                if ($urandom_range(0, 1) == 1) send(p, int'($urandom_range(1, 4)), 1'b0);
            end
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #2;
        end
        wait_drain("random");
        rdy_mode = 0;
    endtask

    task automatic test_rsp_routing();
        int beat = 0;
        int k = 0;
        int tid;
        logic [NP-1:0] exp_mv;
        logic exp_rdy;
        while (beat < 2 && k < 20) begin
            rsp_tvalid   = 1'b1;
            rsp_ttid     = 5'd9;
            rsp_tdata    = $urandom;
            rsp_tkeep    = 4'($urandom);
            rsp_tlast    = (beat == 1);
            m_rsp_tready = 4'($urandom);
            m_rsp_tready[1] = k[0];
            #1;
            checks++;
            if (m_rsp_tvalid !== 4'b0010 || rsp_tready !== m_rsp_tready[1] ||
                m_rsp_tdata !== rsp_tdata) begin
                errors++;
                $display("FAIL rsp_route: got mv=%0b rdy=%0b expected mv=0010 rdy=%0b",
                         m_rsp_tvalid, rsp_tready, m_rsp_tready[1]);
            end
            if (rsp_tready) beat++;
            @(posedge clk);
            #2;
            k++;
            if (beat == 1) begin
                checks++;
                if (idle !== 1'b0) begin
                    errors++; $display("FAIL rsp_open_idle: got %0b expected 0", idle);
                end
            end
        end
        rsp_tvalid = 1'b0;
        #1;
        checks++;
        if (beat != 2 || idle !== 1'b1) begin
            errors++; $display("FAIL rsp_done: got beats=%0d idle=%0b expected 2/1", beat, idle);
        end
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #2;
            tid          = int'($urandom_range(0, 31));
            rsp_ttid     = 5'(tid);
            rsp_tvalid   = 1'($urandom_range(0, 1));
            rsp_tlast    = 1'b1;
            m_rsp_tready = 4'($urandom);
            #1;
            if (tid >= TB && tid < TB + int'(NP)) begin
                exp_mv  = rsp_tvalid ? (4'b1 << (tid - TB)) : 4'b0;
                exp_rdy = m_rsp_tready[tid - TB];
            end else begin
                exp_mv  = '0;
                exp_rdy = 1'b1;
                if (rsp_tvalid && exp_err < 255) exp_err++;
            end
            checks++;
            if (m_rsp_tvalid !== exp_mv || rsp_tready !== exp_rdy) begin
                errors++;
                $display("FAIL rsp_rand tid %0d: got mv=%0b rdy=%0b expected mv=%0b rdy=%0b",
                         tid, m_rsp_tvalid, rsp_tready, exp_mv, exp_rdy);
            end
        end
        @(posedge clk);
        #2;
        rsp_tvalid = 1'b0;
        checks++;
        if (rsp_err_cnt !== 8'(exp_err)) begin
            errors++; $display("FAIL rsp_rand_err: got %0d expected %0d", rsp_err_cnt, exp_err);
        end
    endtask

    task automatic test_bad_tag();
        int start = exp_err;
        for (int b = 0; b < 3; b++) begin
            rsp_tvalid   = 1'b1;
            rsp_ttid     = 5'd20;
            rsp_tlast    = (b == 2);
            m_rsp_tready = '0;
            #1;
            checks++;
            if (rsp_tready !== 1'b1 || m_rsp_tvalid !== 4'b0) begin
                errors++;
                $display("FAIL bad_tag_beat: got rdy=%0b mv=%0b expected 1/0",
                         rsp_tready, m_rsp_tvalid);
            end
            @(posedge clk);
            #2;
            if (b < 2) begin
                checks++;
                if (rsp_err_cnt !== 8'(start)) begin
                    errors++; $display("FAIL bad_tag_early: got %0d expected %0d",
                                       rsp_err_cnt, start);
                end
            end
        end
        exp_err = (start < 255) ? start + 1 : 255;
        checks++;
        if (rsp_err_cnt !== 8'(exp_err)) begin
            errors++; $display("FAIL bad_tag_cnt: got %0d expected %0d", rsp_err_cnt, exp_err);
        end
        rsp_tlast = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
        end
        rsp_tvalid = 1'b0;
        checks++;
        if (rsp_err_cnt !== 8'd255) begin
            errors++; $display("FAIL bad_tag_sat: got %0d expected 255", rsp_err_cnt);
        end
    endtask

    task automatic test_reset_mid_packet();
        int base = acc_cnt[3];
        int n = 0;
        send(3, 4, 1'b0);
        while (acc_cnt[3] < base + 1 && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        rst   = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if (req_tvalid !== 1'b0 || idle !== 1'b1 || rsp_err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL mid_rst: got tvalid=%0b idle=%0b err=%0d expected 0/1/0",
                     req_tvalid, idle, rsp_err_cnt);
        end
        for (int p = 0; p < int'(NP); p++) exp_q[p].delete();
        open    = 0;
        exp_err = 0;
        rst     = 1'b0;
        clear_logs();
        send(3, 1, 1'b0);
        send(0, 1, 1'b0);
        wait_drain("mid_rst");
        checks++;
        if (out_ports.size() != 2 || out_ports[0] != 0 || out_ports[1] != 3) begin
            errors++;
            $display("FAIL mid_rst_order: got first %0d expected 0 then 3",
                     (out_ports.size() > 0) ? out_ports[0] : -1);
        end
    endtask

    initial begin
        rst          = 1'b1;
        s_req_tvalid = '0;
        s_req_tdata  = '0;
        s_req_tkeep  = '0;
        s_req_tlast  = '0;
        req_tready   = 1'b1;
        rsp_tvalid   = 1'b0;
        rsp_tdata    = '0;
        rsp_tkeep    = '0;
        rsp_tlast    = 1'b0;
        rsp_ttid     = '0;
        m_rsp_tready = '0;
        acc          = '0;
        for (int p = 0; p < int'(NP); p++) acc_cnt[p] = 0;
        test_reset();
        test_single_packet();
        test_contention();
        test_backpressure();
        test_random_traffic();
        test_rsp_routing();
        test_bad_tag();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
